// File: rtl/apb_mem_slave.sv
`timescale 1ns/1ps
// apb_mem_slave: APB4 completer over a DEPTH x DATA_WIDTH word memory with wait states and byte strobes.
// Optional feature macro APB_SLVERR_EN: flag misaligned / out-of-range transfers with slverr instead of wrapping.
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic                    sel,
  input  logic                    enable,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ready,
  output logic                    slverr,
  output logic                    state_dbg
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int LSB  = $clog2(NB);
  localparam int IDXW = $clog2(DEPTH);

  // Handshake: a transfer starts with a setup cycle (sel=1, enable=0) and completes
  // on the first access cycle where ready=1; the master holds addr/wr/wdata/strb
  // stable until then. Dropping sel during the access phase abandons the transfer.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDXW-1:0]       idx;
  logic                  err;
  logic                  done;

  assign idx = addr[LSB +: IDXW];

`ifdef APB_SLVERR_EN
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((64'd1 << LSB) - 64'd1);
  logic [ADDR_WIDTH-1:0] word_addr;

  assign word_addr = addr >> LSB;
  assign err       = (|(addr & LOW_MASK)) || (word_addr >= ADDR_WIDTH'(DEPTH));
`else
  // Low bits and bits above the index are don't-care: the index wraps modulo DEPTH.
  logic addr_unused;

  assign addr_unused = ^addr;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (sel && !enable) begin
          state_n = ACCESS;
          cnt_n   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!sel) begin
          state_n = IDLE;
        end else if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign done      = (state == ACCESS) && sel && (cnt == 4'd0);
  assign ready     = done;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (done && wr && !err) begin
      for (int b = 0; b < NB; b++) begin
        if (strb[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = (done && !wr && !err) ? mem[idx] : '0;

`ifdef APB_SLVERR_EN
  assign slverr = done && err;
`else
  assign slverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_mem_slave.sv
`timescale 1ns/1ps
// tb_apb_mem_slave: directed vectors against two instances (WAIT_STATES=0 and WAIT_STATES=3).
module tb_apb_mem_slave;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 64;

`ifdef APB_SLVERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  int   cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  logic          wr_v     [2];
  logic          sel_v    [2];
  logic          en_v     [2];
  logic [AW-1:0] addr_v   [2];
  logic [DW-1:0] wdata_v  [2];
  logic [NB-1:0] strb_v   [2];
  logic [DW-1:0] rdata_v  [2];
  logic          ready_v  [2];
  logic          slverr_v [2];
  logic          state_v  [2];

  apb_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .wr(wr_v[0]), .sel(sel_v[0]), .enable(en_v[0]),
    .addr(addr_v[0]), .wdata(wdata_v[0]), .strb(strb_v[0]),
    .rdata(rdata_v[0]), .ready(ready_v[0]), .slverr(slverr_v[0]), .state_dbg(state_v[0])
  );

  apb_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .wr(wr_v[1]), .sel(sel_v[1]), .enable(en_v[1]),
    .addr(addr_v[1]), .wdata(wdata_v[1]), .strb(strb_v[1]),
    .rdata(rdata_v[1]), .ready(ready_v[1]), .slverr(slverr_v[1]), .state_dbg(state_v[1])
  );

  // scoreboard
  int            tests_run    = 0;
  int            tests_failed = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic xfer(input int d, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [NB-1:0] s, output logic [DW-1:0] rd, output logic se, output int cyc);
    @(posedge clk); #1;
    sel_v[d] = 1'b1; en_v[d] = 1'b0; wr_v[d] = w; addr_v[d] = a; wdata_v[d] = wd; strb_v[d] = s;
    cyc = 1; rd = '0; se = 1'b0;
    forever begin
      @(posedge clk); #1;
      en_v[d] = 1'b1;
      cyc++;
      @(negedge clk);
      if (ready_v[d]) begin
        rd = rdata_v[d];
        se = slverr_v[d];
        break;
      end
      if (cyc > 40) break;
    end
  endtask

  task automatic idle(input int d);
    @(posedge clk); #1;
    sel_v[d] = 1'b0; en_v[d] = 1'b0;
  endtask

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [NB-1:0] s;
    logic [DW-1:0] exp_rd;
    logic          exp_se;
  } vec_t;

  vec_t vt[13];

  initial begin
    logic [DW-1:0] rd;
    logic          se;
    int            cyc;
    int            t0;

    vt[0]  = '{1'b1, 32'h10,  32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vt[1]  = '{1'b0, 32'h10,  32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h04,  32'h1122_3344, 4'hF, 32'h0,         1'b0};
    vt[3]  = '{1'b1, 32'h04,  32'hAABB_CCDD, 4'h5, 32'h0,         1'b0};
    vt[4]  = '{1'b0, 32'h04,  32'h0,         4'hF, 32'h11BB_33DD, 1'b0};
    vt[5]  = '{1'b1, 32'h08,  32'h1234_5678, 4'h0, 32'h0,         1'b0};
    vt[6]  = '{1'b0, 32'h08,  32'h0,         4'h0, 32'h0,         1'b0};
    vt[7]  = '{1'b1, 32'h100, 32'h55AA_55AA, 4'hF, 32'h0,         ERR_EN};
    vt[8]  = '{1'b0, 32'h00,  32'h0,         4'h0, ERR_EN ? 32'h0 : 32'h55AA_55AA, 1'b0};
    vt[9]  = '{1'b0, 32'h02,  32'h0,         4'h0, ERR_EN ? 32'h0 : 32'h55AA_55AA, ERR_EN};
    vt[10] = '{1'b1, 32'hFC,  32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
    vt[11] = '{1'b0, 32'hFC,  32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    vt[12] = '{1'b0, 32'h10,  32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};

    for (int d = 0; d < 2; d++) begin
      wr_v[d] = 1'b0; sel_v[d] = 1'b0; en_v[d] = 1'b0;
      addr_v[d] = '0; wdata_v[d] = '0; strb_v[d] = '0;
    end
    rst = 1'b0;
    #3;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_ready[%0d]", d),  32'(ready_v[d]),  32'h0);
      check($sformatf("reset_rdata[%0d]", d),  rdata_v[d],       32'h0);
      check($sformatf("reset_slverr[%0d]", d), 32'(slverr_v[d]), 32'h0);
      check($sformatf("reset_state[%0d]", d),  32'(state_v[d]),  32'h0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // enable without a setup phase must not start a transfer
    @(posedge clk); #1;
    sel_v[0] = 1'b1; en_v[0] = 1'b1;
    @(negedge clk);
    check("no_setup_ready", 32'(ready_v[0]), 32'h0);
    @(negedge clk);
    check("no_setup_state", 32'(state_v[0]), 32'h0);
    idle(0);

    // table-driven vectors on the zero-wait instance, applied back to back
    for (int i = 0; i < 13; i++) begin
      xfer(0, vt[i].w, vt[i].a, vt[i].wd, vt[i].s, rd, se, cyc);
      check($sformatf("vec%0d_rdata", i),  rd,      vt[i].exp_rd);
      check($sformatf("vec%0d_slverr", i), 32'(se), 32'(vt[i].exp_se));
      check($sformatf("vec%0d_cycles", i), cyc,     2);
    end
    idle(0);

    // three wait states: ready on the 5th cycle after setup
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, se, cyc);
    check("ws3_read_rdata", rd, 32'h0);
    check("ws3_read_cycles", cyc, 5);

    // back-to-back: 8 writes then 8 reads with no idle cycle
    t0 = cyc_cnt;
    for (int k = 0; k < 8; k++) begin
      logic [DW-1:0] dat;
      dat = 32'h0101_0101 * 32'(k + 1) ^ 32'hF000_000F;
      exp_q.push_back(dat);
      xfer(1, 1'b1, 32'(32'h20 + 4 * k), dat, 4'hF, rd, se, cyc);
      check($sformatf("b2b_wr%0d_cycles", k), cyc, 5);
    end
    for (int k = 0; k < 8; k++) begin
      logic [DW-1:0] exp;
      exp = exp_q.pop_front();
      xfer(1, 1'b0, 32'(32'h20 + 4 * k), 32'h0, 4'h0, rd, se, cyc);
      check($sformatf("b2b_rd%0d_rdata", k),  rd,  exp);
      check($sformatf("b2b_rd%0d_cycles", k), cyc, 5);
    end
    check("b2b_total_cycles", cyc_cnt - t0, 80);
    idle(1);

    // abort: drop sel during an access wait cycle
    @(posedge clk); #1;
    sel_v[1] = 1'b1; en_v[1] = 1'b0; wr_v[1] = 1'b1; addr_v[1] = 32'h20;
    wdata_v[1] = 32'hFFFF_FFFF; strb_v[1] = 4'hF;
    @(posedge clk); #1 en_v[1] = 1'b1;
    @(negedge clk);
    check("abort_wait_ready", 32'(ready_v[1]), 32'h0);
    @(posedge clk); #1 sel_v[1] = 1'b0;
    @(negedge clk);
    check("abort_drop_ready", 32'(ready_v[1]), 32'h0);
    @(posedge clk); #1 en_v[1] = 1'b0;
    @(negedge clk);
    check("abort_state", 32'(state_v[1]), 32'h0);
    check("abort_ready_after", 32'(ready_v[1]), 32'h0);
    xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, se, cyc);
    check("abort_mem_unchanged", rd, 32'h0101_0101 ^ 32'hF000_000F);
    idle(1);

    // reset asserted in the middle of a write with wait states
    @(posedge clk); #1;
    sel_v[1] = 1'b1; en_v[1] = 1'b0; wr_v[1] = 1'b1; addr_v[1] = 32'h24;
    wdata_v[1] = 32'h1357_9BDF; strb_v[1] = 4'hF;
    @(posedge clk); #1 en_v[1] = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
    #1;
    check("midrst_ready",  32'(ready_v[1]),  32'h0);
    check("midrst_rdata",  rdata_v[1],       32'h0);
    check("midrst_slverr", 32'(slverr_v[1]), 32'h0);
    check("midrst_state",  32'(state_v[1]),  32'h0);
    @(posedge clk); #1 sel_v[1] = 1'b0; en_v[1] = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    xfer(1, 1'b0, 32'h24, 32'h0, 4'h0, rd, se, cyc);
    check("midrst_lost_write", rd, 32'h0);
    xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, se, cyc);
    check("midrst_mem_cleared", rd, 32'h0);
    idle(1);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, se, cyc);
    check("midrst_mem_cleared0", rd, 32'h0);
    idle(0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
